// File: rtl/fpu_cvt_int2fp_stage.sv
// Two-stage FCVT.S.W / FCVT.S.WU issue/retire pipeline around fpu_cvt_to_float.
// Ports: clk_i, reset_i (sync, active low), in_* / out_* valid-ready, frm_i, flush_i.

module fpu_cvt_to_float (
  input  logic [31:0] a_i,
  input  logic        unsigned_i,
  input  logic [2:0]  rm_i,
  output logic [31:0] result_o
);
  logic        sign;
  logic [31:0] mag;
  logic [31:0] norm;
  logic [4:0]  p;
  logic        g;
  logic        s;
  logic        inc;
  logic [30:0] body;

  always_comb begin
    sign = ~unsigned_i & a_i[31];
    mag  = sign ? (~a_i + 32'd1) : a_i;
    p    = 5'd0;
    for (int i = 0; i < 32; i++)
      if (mag[i]) p = 5'(i);
    // Put the leading one at bit 31; bits 30:8 become the fraction.
    norm = mag << (5'd31 - p);
    g    = norm[7];
    s    = |norm[6:0];
    unique case (rm_i)
      3'b000:  inc = g & (s | norm[8]);
      3'b010:  inc = sign & (g | s);
      3'b011:  inc = ~sign & (g | s);
      3'b100:  inc = g;
      default: inc = 1'b0;
    endcase
    // A mantissa carry ripples into the exponent, which cannot overflow.
    body = {8'(p) + 8'd127, norm[30:8]} + {30'd0, inc};
    if (mag == 32'd0)
      result_o = 32'd0;
    else
      result_o = {sign, body};
  end
endmodule

module fpu_cvt_int2fp_stage #(
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_a_i,
  input  logic             in_unsigned_i,
  input  logic [2:0]       in_rm_i,
  input  logic [TAG_W-1:0] in_tag_i,
  input  logic [2:0]       frm_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_result_o,
  output logic [4:0]       out_fflags_o,
  output logic             out_illegal_o,
  output logic [TAG_W-1:0] out_tag_o
);
  logic             s1_valid;
  logic [31:0]      s1_a;
  logic             s1_uns;
  logic [2:0]       s1_rm;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid;

  logic             accept;
  logic             s1_adv;
  logic [2:0]       rm_res;
  logic [31:0]      cvt_res;
  logic             s1_ill;
  logic [31:0]      mag;
  logic [4:0]       p;
  logic [31:0]      low_mask;
  logic             nx;

  assign rm_res     = (in_rm_i == 3'b111) ? frm_i : in_rm_i;
  assign s1_adv     = s1_valid & (~s2_valid | out_ready_i);
  assign in_ready_o = ~flush_i & (~s1_valid | s1_adv);
  assign accept     = in_valid_i & in_ready_o;
  assign s1_ill     = (s1_rm == 3'b101) | (s1_rm == 3'b110) |
                      (s1_rm == 3'b111);
  assign out_valid_o = s2_valid;

  fpu_cvt_to_float u_cvt (
    .a_i        (s1_a),
    .unsigned_i (s1_uns),
    .rm_i       (s1_rm),
    .result_o   (cvt_res)
  );

  // Inexact iff |A| has set bits below the 24 kept significant bits.
  always_comb begin
    mag = (~s1_uns & s1_a[31]) ? (~s1_a + 32'd1) : s1_a;
    p   = 5'd0;
    for (int i = 0; i < 32; i++)
      if (mag[i]) p = 5'(i);
    low_mask = 32'd0;
    nx       = 1'b0;
    if (p >= 5'd24) begin
      low_mask = (32'd1 << (p - 5'd23)) - 32'd1;
      nx       = |(mag & low_mask);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      s1_valid <= 1'b0;
      s1_a     <= 32'd0;
      s1_uns   <= 1'b0;
      s1_rm    <= 3'd0;
      s1_tag   <= '0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a_i;
      s1_uns   <= in_unsigned_i;
      s1_rm    <= rm_res;
      s1_tag   <= in_tag_i;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      s2_valid      <= 1'b0;
      out_result_o  <= 32'd0;
      out_fflags_o  <= 5'd0;
      out_illegal_o <= 1'b0;
      out_tag_o     <= '0;
    end else if (flush_i) begin
      s2_valid <= 1'b0;
    end else if (s1_adv) begin
      s2_valid      <= 1'b1;
      out_result_o  <= s1_ill ? 32'd0 : cvt_res;
      out_fflags_o  <= {4'd0, ~s1_ill & nx};
      out_illegal_o <= s1_ill;
      out_tag_o     <= s1_tag;
    end else if (out_ready_i) begin
      s2_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fpu_cvt_int2fp_stage.sv
// Scoreboard bench for fpu_cvt_int2fp_stage: directed FCVT.S.W(U) vectors,
// backpressure stream, and flush with ops in flight.

module tb_fpu_cvt_int2fp_stage;
  localparam int TAG_W = 5;

  typedef struct packed {
    logic [31:0]      res;
    logic [4:0]       ff;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 0;
  logic             reset_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      in_a_i;
  logic             in_unsigned_i;
  logic [2:0]       in_rm_i;
  logic [TAG_W-1:0] in_tag_i;
  logic [2:0]       frm_i;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [31:0]      out_result_o;
  logic [4:0]       out_fflags_o;
  logic             out_illegal_o;
  logic [TAG_W-1:0] out_tag_o;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   saw_bp = 0;
  bit   held_v = 0;
  exp_t held;

  always #5 clk = ~clk;

  fpu_cvt_int2fp_stage #(.TAG_W(TAG_W)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_a_i        (in_a_i),
    .in_unsigned_i (in_unsigned_i),
    .in_rm_i       (in_rm_i),
    .in_tag_i      (in_tag_i),
    .frm_i         (frm_i),
    .flush_i       (flush_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_result_o  (out_result_o),
    .out_fflags_o  (out_fflags_o),
    .out_illegal_o (out_illegal_o),
    .out_tag_o     (out_tag_o)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Inputs change only at posedge+1; the monitor samples at negedge.
  always @(negedge clk) begin
    exp_t cur;
    cur = {out_result_o, out_fflags_o, out_illegal_o, out_tag_o};
    if (in_valid_i && !in_ready_o && !flush_i && out_valid_o)
      saw_bp = 1;
    if (reset_i && out_valid_o && held_v) begin
      checks++;
      if (cur !== held) begin
        errors++;
        $display("FAIL stall_hold got %0h want %0h", cur, held);
      end
    end
    held_v = 0;
    if (reset_i && out_valid_o && !out_ready_i) begin
      held_v = 1;
      held   = cur;
    end
    if (reset_i && out_valid_o && out_ready_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got %0h want none", cur);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL result tag %0d got %0h want %0h", e.tag, cur, e);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic uns,
                       input logic [2:0] rm, input logic [2:0] frm,
                       input logic [TAG_W-1:0] tag, input logic [31:0] res,
                       input logic nx, input logic ill, input bit push);
    int n;
    in_valid_i    = 1;
    in_a_i        = a;
    in_unsigned_i = uns;
    in_rm_i       = rm;
    frm_i         = frm;
    in_tag_i      = tag;
    n = 0;
    @(negedge clk);
    while (!in_ready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got 0 want 1");
    end else if (push) begin
      sb.push_back({res, {4'd0, nx}, ill, tag});
    end
    @(posedge clk);
    #1 in_valid_i = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d want 0", sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i = 0; in_valid_i = 0; in_a_i = 0; in_unsigned_i = 0;
    in_rm_i = 0; in_tag_i = 0; frm_i = 0; flush_i = 0; out_ready_i = 1;
    repeat (3) @(posedge clk);
    #1 reset_i = 1;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_result", 64'(out_result_o), 64'd0);
    chk("rst_fflags", 64'(out_fflags_o), 64'd0);
    chk("rst_illegal", 64'(out_illegal_o), 64'd0);
    chk("rst_tag", 64'(out_tag_o), 64'd0);
    chk("rst_ready", 64'(in_ready_o), 64'd1);
    @(posedge clk); #1;

    // Latency: accepted at edge N, valid after edge N+1.
    issue(32'hFFFFFFFF, 0, 3'b000, 3'b000, 5'd1, 32'hBF800000, 0, 0, 1);
    chk("lat_n", 64'(out_valid_o), 64'd0);
    @(posedge clk); #1;
    chk("lat_n1", 64'(out_valid_o), 64'd1);
    drain();

    issue(32'h01000001, 0, 3'b000, 3'b000, 5'd2, 32'h4B800000, 1, 0, 1);
    issue(32'h01000001, 0, 3'b011, 3'b000, 5'd3, 32'h4B800001, 1, 0, 1);
    issue(32'hFFFFFFFF, 1, 3'b000, 3'b000, 5'd4, 32'h4F800000, 1, 0, 1);
    issue(32'hFFFFFFFF, 1, 3'b001, 3'b000, 5'd5, 32'h4F7FFFFF, 1, 0, 1);
    issue(32'h80000001, 0, 3'b111, 3'b010, 5'd6, 32'hCF000000, 1, 0, 1);
    issue(32'h80000001, 0, 3'b111, 3'b101, 5'd7, 32'h00000000, 0, 1, 1);
    issue(32'h00000005, 0, 3'b110, 3'b000, 5'd8, 32'h00000000, 0, 1, 1);
    issue(32'h00000000, 0, 3'b000, 3'b000, 5'd9, 32'h00000000, 0, 0, 1);
    issue(32'h00FFFFFF, 0, 3'b000, 3'b000, 5'd10, 32'h4B7FFFFF, 0, 0, 1);
    issue(32'h80000000, 0, 3'b000, 3'b000, 5'd11, 32'hCF000000, 0, 0, 1);
    issue(32'h01000003, 0, 3'b100, 3'b000, 5'd12, 32'h4B800002, 1, 0, 1);
    drain();

    // Back-to-back stream with writeback stalled for cycles 3-5.
    fork
      begin
        issue(32'd1, 0, 3'b000, 3'b000, 5'd16, 32'h3F800000, 0, 0, 1);
        issue(32'd2, 0, 3'b000, 3'b000, 5'd17, 32'h40000000, 0, 0, 1);
        issue(32'd3, 1, 3'b000, 3'b000, 5'd18, 32'h40400000, 0, 0, 1);
        issue(32'hFFFFFFFE, 0, 3'b000, 3'b000, 5'd19, 32'hC0000000, 0, 0, 1);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready_i = 0;
        repeat (3) @(posedge clk);
        #1 out_ready_i = 1;
      end
    join
    drain();
    chk("backpressure_seen", 64'(saw_bp), 64'd1);

    // Flush with two ops in flight; nothing may emerge.
    out_ready_i = 0;
    issue(32'd7, 0, 3'b000, 3'b000, 5'd20, 32'h40E00000, 0, 0, 0);
    issue(32'd9, 0, 3'b000, 3'b000, 5'd21, 32'h41100000, 0, 0, 0);
    @(posedge clk); #1;
    flush_i = 1; in_valid_i = 1; in_a_i = 32'd4; in_tag_i = 5'd22;
    @(negedge clk);
    chk("flush_ready", 64'(in_ready_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 0; in_valid_i = 0; out_ready_i = 1;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("flush_quiet", 64'(out_valid_o), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
